// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// flush/hazard/idle decode, downstream hold, and saturating stall/flush counters.
module id_ex_pipe #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          RegDs,
  input  logic          Branch,
  input  logic          MRead,
  input  logic          MtoR,
  input  logic          MWrite,
  input  logic          ALUsrc,
  input  logic          Urw,
  input  logic [2:0]    AOp,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [DW-1:0] imm,
  input  logic [DW-1:0] pc4,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic [RW-1:0] rd,
  input  logic          flush,
  input  logic          hold,
  output logic          ex_valid,
  output logic          ex_RegDs,
  output logic          ex_Branch,
  output logic          ex_MRead,
  output logic          ex_MtoR,
  output logic          ex_MWrite,
  output logic          ex_ALUsrc,
  output logic          ex_Urw,
  output logic [2:0]    ex_AOp,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic          stall,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // Control bundle packed as {RegDs, Branch, MRead, MtoR, MWrite, ALUsrc, Urw, AOp}
  logic [9:0]    ctrl_in_s;
  logic [9:0]    ctrl_q, ctrl_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q, imm_d, pc4_q, pc4_d;
  logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic          lu_s, stall_s, bubble_s;

  assign ctrl_in_s = {RegDs, Branch, MRead, MtoR, MWrite, ALUsrc, Urw, AOp};

  // Load-use hazard and stall generation from current EX state and decode inputs
  always_comb begin
    lu_s = valid_q & ctrl_q[7] & (rt_q != {RW{1'b0}}) & in_valid
           & ((rt_q == rs) | (rt_q == rt));
    stall_s  = ~flush & (hold | lu_s);
    bubble_s = flush | lu_s | ~in_valid;
  end

  // Next-state of the pipeline register: flush > hold > hazard/idle bubble > load
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    pc4_d     = pc4_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    if (flush || !hold) begin
      rs_data_d = rs_data;
      rt_data_d = rt_data;
      imm_d     = imm;
      pc4_d     = pc4;
      rs_d      = rs;
      rt_d      = rt;
      rd_d      = rd;
      // Bubbles force controls to zero so X controls on idle slots never propagate
      if (bubble_s) begin
        valid_d = 1'b0;
        ctrl_d  = 10'd0;
      end else begin
        valid_d = 1'b1;
        ctrl_d  = ctrl_in_s;
      end
    end else begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
    end
  end

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      ctrl_q      <= 10'd0;
      rs_data_q   <= {DW{1'b0}};
      rt_data_q   <= {DW{1'b0}};
      imm_q       <= {DW{1'b0}};
      pc4_q       <= {DW{1'b0}};
      rs_q        <= {RW{1'b0}};
      rt_q        <= {RW{1'b0}};
      rd_q        <= {RW{1'b0}};
      stall_cnt_q <= {CW{1'b0}};
      flush_cnt_q <= {CW{1'b0}};
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      pc4_q       <= pc4_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_RegDs   = ctrl_q[9];
  assign ex_Branch  = ctrl_q[8];
  assign ex_MRead   = ctrl_q[7];
  assign ex_MtoR    = ctrl_q[6];
  assign ex_MWrite  = ctrl_q[5];
  assign ex_ALUsrc  = ctrl_q[4];
  assign ex_Urw     = ctrl_q[3];
  assign ex_AOp     = ctrl_q[2:0];
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_pc4     = pc4_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign stall      = stall_s;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe, built with CW=4 so the
// counter saturation point is reachable in a short run.
module tb_id_ex_pipe;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, in_valid, flush, hold;
  logic          RegDs, Branch, MRead, MtoR, MWrite, ALUsrc, Urw;
  logic [2:0]    AOp;
  logic [DW-1:0] rs_data, rt_data, imm, pc4;
  logic [RW-1:0] rs, rt, rd;
  logic          ex_valid, ex_RegDs, ex_Branch, ex_MRead, ex_MtoR, ex_MWrite, ex_ALUsrc, ex_Urw;
  logic [2:0]    ex_AOp;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic          stall;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  localparam logic [9:0] C_RTYPE = 10'b1001001_010;
  localparam logic [9:0] C_LW    = 10'b0011011_000;
  localparam logic [9:0] C_ZERO  = 10'b0000000_000;

  logic [9:0] ex_ctrl;
  assign ex_ctrl = {ex_RegDs, ex_Branch, ex_MRead, ex_MtoR, ex_MWrite, ex_ALUsrc, ex_Urw, ex_AOp};

  always #5 clk = ~clk;

  id_ex_pipe #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .RegDs(RegDs), .Branch(Branch), .MRead(MRead), .MtoR(MtoR), .MWrite(MWrite),
    .ALUsrc(ALUsrc), .Urw(Urw), .AOp(AOp),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .pc4(pc4),
    .rs(rs), .rt(rt), .rd(rd), .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_RegDs(ex_RegDs), .ex_Branch(ex_Branch), .ex_MRead(ex_MRead),
    .ex_MtoR(ex_MtoR), .ex_MWrite(ex_MWrite), .ex_ALUsrc(ex_ALUsrc), .ex_Urw(ex_Urw),
    .ex_AOp(ex_AOp), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ctrl(input logic [9:0] c);
    {RegDs, Branch, MRead, MtoR, MWrite, ALUsrc, Urw, AOp} = c;
  endtask

  task automatic set_instr(input logic [9:0] c, input logic [RW-1:0] s, input logic [RW-1:0] t,
                           input logic [RW-1:0] d, input logic [DW-1:0] base);
    in_valid = 1'b1;
    set_ctrl(c);
    rs = s; rt = t; rd = d;
    rs_data = base + 32'd1; rt_data = base + 32'd2; imm = base + 32'd3; pc4 = base + 32'd4;
  endtask

  initial begin
    // Reset with every input unknown
    reset = 1'b1; in_valid = 1'bx; flush = 1'bx; hold = 1'bx;
    set_ctrl(10'bx); rs_data = 'x; rt_data = 'x; imm = 'x; pc4 = 'x; rs = 'x; rt = 'x; rd = 'x;
    @(negedge clk);
    tick();
    check("rst_valid", ex_valid, 1'b0);
    check("rst_ctrl", ex_ctrl, C_ZERO);
    check("rst_data", {ex_rs_data, ex_imm}, 64'd0);
    check("rst_regs", {ex_rs, ex_rt, ex_rd}, 15'd0);
    check("rst_cnts", {stall_cnt, flush_cnt}, 8'd0);
    reset = 1'b0; flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
    #1 check("rst_stall", stall, 1'b0);

    // Normal R-type load
    set_instr(C_RTYPE, 5'd2, 5'd3, 5'd4, 32'hA000_0000);
    tick();
    check("rt_valid", ex_valid, 1'b1);
    check("rt_ctrl", ex_ctrl, C_RTYPE);
    check("rt_regs", {ex_rs, ex_rt, ex_rd}, {5'd2, 5'd3, 5'd4});
    check("rt_data", {ex_rs_data, ex_pc4}, {32'hA000_0001, 32'hA000_0004});
    check("rt_stall", stall, 1'b0);

    // Load-use: lw to r5, then consumer of r5
    set_instr(C_LW, 5'd1, 5'd5, 5'd0, 32'hB000_0000);
    tick();
    check("lw_ctrl", ex_ctrl, C_LW);
    set_instr(C_RTYPE, 5'd5, 5'd7, 5'd8, 32'hC000_0000);
    #1 check("lu_stall", stall, 1'b1);
    tick();
    check("lu_bub_valid", ex_valid, 1'b0);
    check("lu_bub_ctrl", ex_ctrl, C_ZERO);
    check("lu_after_stall", stall, 1'b0);
    check("lu_stall_cnt", stall_cnt, 4'd1);
    tick();
    check("lu_dep_valid", ex_valid, 1'b1);
    check("lu_dep_rs", ex_rs, 5'd5);
    check("lu_dep_ctrl", ex_ctrl, C_RTYPE);

    // Load to r0 is never a hazard
    set_instr(C_LW, 5'd1, 5'd0, 5'd0, 32'hD000_0000);
    tick();
    set_instr(C_RTYPE, 5'd0, 5'd0, 5'd9, 32'hD100_0000);
    #1 check("r0_stall", stall, 1'b0);
    tick();
    check("r0_valid", ex_valid, 1'b1);
    check("r0_stall_cnt", stall_cnt, 4'd1);

    // Flush with a simultaneous load-use hazard
    set_instr(C_LW, 5'd1, 5'd6, 5'd0, 32'hE000_0000);
    tick();
    set_instr(C_RTYPE, 5'd6, 5'd2, 5'd3, 32'hE100_0000);
    flush = 1'b1;
    #1 check("fl_lu_stall", stall, 1'b0);
    tick();
    flush = 1'b0;
    check("fl_valid", ex_valid, 1'b0);
    check("fl_ctrl", ex_ctrl, C_ZERO);
    check("fl_cnts", {stall_cnt, flush_cnt}, {4'd1, 4'd1});

    // Hold for three cycles with changing inputs
    set_instr(C_RTYPE, 5'd10, 5'd11, 5'd9, 32'hF000_0000);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(C_LW, 5'd20 + 5'(i), 5'd21, 5'd22 + 5'(i), 32'h1000_0000 * (i + 1));
      #1 check("hold_stall", stall, 1'b1);
      tick();
      check("hold_rd", ex_rd, 5'd9);
      check("hold_ctrl", {ex_valid, ex_ctrl}, {1'b1, C_RTYPE});
    end
    check("hold_stall_cnt", stall_cnt, 4'd4);
    hold = 1'b0;
    set_instr(C_RTYPE, 5'd1, 5'd2, 5'd12, 32'h2200_0000);
    tick();
    check("rel_rd", ex_rd, 5'd12);
    check("rel_imm", ex_imm, 32'h2200_0003);

    // Hold and flush together: flush wins
    hold = 1'b1; flush = 1'b1;
    #1 check("hf_stall", stall, 1'b0);
    tick();
    check("hf_valid", ex_valid, 1'b0);
    check("hf_flush_cnt", flush_cnt, 4'd2);
    hold = 1'b0;

    // X controls on an idle decode slot become a clean bubble
    flush = 1'b0; in_valid = 1'b0; set_ctrl(10'bx);
    tick();
    check("idle_ctrl", {ex_valid, ex_ctrl}, 11'd0);

    // Flush counter saturation
    flush = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_flush_cnt", flush_cnt, 4'd15);
    check("sat_stall_cnt", stall_cnt, 4'd4);
    flush = 1'b0;

    // Reset in the middle of a hold
    set_instr(C_RTYPE, 5'd3, 5'd4, 5'd5, 32'h3300_0000);
    tick();
    hold = 1'b1;
    #1 check("mid_hold_stall", stall, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0; hold = 1'b0;
    check("mid_rst_state", {ex_valid, ex_ctrl, ex_rd}, 16'd0);
    check("mid_rst_cnts", {stall_cnt, flush_cnt}, 8'd0);
    #1 check("mid_rst_stall", stall, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
